// File: rtl/video_overlay_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : video_overlay_mixer
//  Description : Resolves the sprite overlay index through a CPU-written
//                256-entry RGBA palette, blends it onto the framebuffer pixel
//                and delivers aligned RGB plus blanking two cycles later.
//                The CPU writes control and palette over a request/ready bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_overlay_mixer #(
    parameter logic [1:0] INIT_CONTROL = 2'b00
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // CPU register bus (write-only)
    input  logic        i_request,
    input  logic [15:0] i_address,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    // Pixel inputs, all aligned to the same beat
    input  logic        i_video_hblank,
    input  logic        i_video_vblank,
    input  logic [23:0] i_fb_data,
    input  logic [7:0]  i_overlay_data,
    input  logic        i_overlay_mask,
    // Mixed pixel outputs
    output logic        o_video_hblank,
    output logic        o_video_vblank,
    output logic [23:0] o_video_data
);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    localparam logic [3:0] C_REGION_REGS    = 4'h0;
    localparam logic [3:0] C_REGION_PALETTE = 4'h1;

    logic w_ctrl_write;
    logic w_pal_write;
    logic [7:0] w_pal_waddr;

    // Control lives at word offset 0 of the register region; byte lanes
    // within the word are not decoded.
    assign w_ctrl_write = i_request
                        && (i_address[15:12] == C_REGION_REGS)
                        && (i_address[11:2] == 10'd0);
    assign w_pal_write  = i_request && (i_address[15:12] == C_REGION_PALETTE);
    assign w_pal_waddr  = i_address[9:2];

    // Byte-lane address bits carry no meaning on this word-wide bus.
    logic unused_addr_lanes;
    assign unused_addr_lanes = ^i_address[1:0];

    // ------------------------------------------------------------------------
    // Bus acknowledge and control register
    // ------------------------------------------------------------------------
    logic       ready_q;
    logic [1:0] control_q;
    logic [1:0] control_d;

    // Next control value: load on a decoded control write, else hold.
    always_comb begin
        control_d = control_q;
        if (w_ctrl_write) begin
            control_d = i_wdata[1:0];
        end
    end

    // Every request is acked exactly one cycle later; control is updated.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ready_q   <= 1'b0;
            control_q <= INIT_CONTROL;
        end else begin
            ready_q   <= i_request;
            control_q <= control_d;
        end
    end

    assign o_ready = ready_q;

    // ------------------------------------------------------------------------
    // Palette RAM: 256 x {alpha, R, G, B}, not cleared by reset
    // ------------------------------------------------------------------------
    logic [31:0] palette_mem [256];
    logic [31:0] pal_rdata_q;

    // Write and read share one edge; the nonblocking read samples the old
    // entry when the same index is written, giving read-before-write.
    always_ff @(posedge i_clock) begin
        if (w_pal_write) begin
            palette_mem[w_pal_waddr] <= i_wdata;
        end
        pal_rdata_q <= palette_mem[i_overlay_data];
    end

    // ------------------------------------------------------------------------
    // Stage 1: side-band registers aligned with the palette read
    // ------------------------------------------------------------------------
    logic [23:0] fb_s1_q;
    logic        mask_s1_q;
    logic        hblank_s1_q;
    logic        vblank_s1_q;

    // Capture framebuffer pixel, mask and blanking alongside the palette read.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fb_s1_q     <= 24'd0;
            mask_s1_q   <= 1'b0;
            hblank_s1_q <= 1'b1;
            vblank_s1_q <= 1'b1;
        end else begin
            fb_s1_q     <= i_fb_data;
            mask_s1_q   <= i_overlay_mask;
            hblank_s1_q <= i_video_hblank;
            vblank_s1_q <= i_video_vblank;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: blend
    // ------------------------------------------------------------------------
    // One channel of (ov*a' + fb*(256-a')) >> 8 with a' in 0..256.
    function automatic logic [7:0] blend_channel(
        input logic [7:0] ov,
        input logic [7:0] fb,
        input logic [8:0] alpha9
    );
        logic [8:0]  inv;
        logic [16:0] acc;
        inv = 9'd256 - alpha9;
        acc = 17'(ov) * 17'(alpha9) + 17'(fb) * 17'(inv);
        return 8'(acc >> 8);
    endfunction

    logic [7:0]  w_alpha;
    logic [8:0]  w_alpha9;
    logic [23:0] w_ov_rgb;
    logic [23:0] video_d;

    assign w_alpha  = pal_rdata_q[31:24];
    assign w_ov_rgb = pal_rdata_q[23:0];
    // Folding the MSB in maps 255 to 256 so full alpha is exactly opaque.
    assign w_alpha9 = {1'b0, w_alpha} + {8'd0, w_alpha[7]};

    // Select passthrough, opaque overlay or alpha blend; force black in blank.
    always_comb begin
        video_d = fb_s1_q;
        if (control_q[0] && mask_s1_q) begin
            if (!control_q[1]) begin
                video_d = w_ov_rgb;
            end else begin
                video_d = {blend_channel(w_ov_rgb[23:16], fb_s1_q[23:16], w_alpha9),
                           blend_channel(w_ov_rgb[15:8],  fb_s1_q[15:8],  w_alpha9),
                           blend_channel(w_ov_rgb[7:0],   fb_s1_q[7:0],   w_alpha9)};
            end
        end
        if (hblank_s1_q || vblank_s1_q) begin
            video_d = 24'd0;
        end
    end

    logic [23:0] video_q;
    logic        hblank_q;
    logic        vblank_q;

    // Output register: mixed pixel with blanking delayed to match.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            video_q  <= 24'd0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
        end else begin
            video_q  <= video_d;
            hblank_q <= hblank_s1_q;
            vblank_q <= vblank_s1_q;
        end
    end

    assign o_video_data   = video_q;
    assign o_video_hblank = hblank_q;
    assign o_video_vblank = vblank_q;

endmodule
`default_nettype wire

// File: tb/tb_video_overlay_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_overlay_mixer
//  Description : Directed self-checking bench for video_overlay_mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_video_overlay_mixer;

    logic        clk;
    logic        rst;
    logic        request;
    logic [15:0] address;
    logic [31:0] wdata;
    logic        ready;
    logic        hb_in;
    logic        vb_in;
    logic [23:0] fb_in;
    logic [7:0]  ov_in;
    logic        mask_in;
    logic        hb_out;
    logic        vb_out;
    logic [23:0] video_out;

    int checks;
    int failures;

    video_overlay_mixer #(
        .INIT_CONTROL (2'b00)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_request      (request),
        .i_address      (address),
        .i_wdata        (wdata),
        .o_ready        (ready),
        .i_video_hblank (hb_in),
        .i_video_vblank (vb_in),
        .i_fb_data      (fb_in),
        .i_overlay_data (ov_in),
        .i_overlay_mask (mask_in),
        .o_video_hblank (hb_out),
        .o_video_vblank (vb_out),
        .o_video_data   (video_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle bus write, acknowledge checked on the following cycle.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        request = 1'b1;
        address = a;
        wdata   = d;
        tick();
        request = 1'b0;
        chk("write_ack", 32'(ready), 32'd1);
    endtask

    // Present one pixel and check the output two cycles later.
    task automatic pixel(input string tag, input logic [23:0] fb, input logic [7:0] idx,
                         input logic m, input logic [23:0] exp);
        fb_in   = fb;
        ov_in   = idx;
        mask_in = m;
        tick();
        tick();
        chk(tag, 32'(video_out), 32'(exp));
    endtask

    logic [5:0] hb_pat;
    logic [5:0] vb_pat;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        request  = 1'b0;
        address  = 16'h0;
        wdata    = 32'h0;
        hb_in    = 1'b0;
        vb_in    = 1'b0;
        fb_in    = 24'hABCDEF;
        ov_in    = 8'h00;
        mask_in  = 1'b1;

        // Reset held three cycles with active pixels
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_video", 32'(video_out), 32'h0);
            chk("rst_hblank", 32'(hb_out), 32'd1);
            chk("rst_vblank", 32'(vb_out), 32'd1);
            chk("rst_ready", 32'(ready), 32'd0);
        end

        // Release: passthrough appears after two cycles
        rst     = 1'b0;
        fb_in   = 24'h123456;
        mask_in = 1'b0;
        tick();
        chk("refill_blank", 32'(hb_out), 32'd1);
        chk("refill_video", 32'(video_out), 32'h0);
        tick();
        chk("pass_init", 32'(video_out), 32'h123456);
        chk("pass_hblank", 32'(hb_out), 32'd0);
        chk("pass_vblank", 32'(vb_out), 32'd0);

        // Opaque overlay with blend on and alpha 0xFF
        bus_write(16'h1014, 32'hFFFF0000);
        bus_write(16'h0000, 32'h00000003);
        fb_in   = 24'h00FF00;
        ov_in   = 8'd5;
        mask_in = 1'b1;
        tick();
        chk("latency_not_1", 32'(video_out), 32'h123456);
        tick();
        chk("alpha_ff", 32'(video_out), 32'hFF0000);
        pixel("mask_off", 24'h00FF00, 8'd5, 1'b0, 24'h00FF00);

        // Alpha extremes and midpoint
        bus_write(16'h1014, 32'h00FF0000);
        pixel("alpha_00", 24'h00FF00, 8'd5, 1'b1, 24'h00FF00);
        bus_write(16'h1014, 32'h80FF0000);
        pixel("alpha_80", 24'h00FF00, 8'd5, 1'b1, 24'h807E00);

        // Blend disabled, then overlay disabled
        bus_write(16'h0000, 32'h00000001);
        bus_write(16'h1014, 32'h000000FF);
        pixel("opaque_ignores_alpha", 24'h00FF00, 8'd5, 1'b1, 24'h0000FF);
        bus_write(16'h0000, 32'h00000000);
        pixel("overlay_off", 24'h00FF00, 8'd5, 1'b1, 24'h00FF00);

        // Back-to-back bus requests
        chk("ready_idle", 32'(ready), 32'd0);
        request = 1'b1;
        address = 16'h0000; wdata = 32'h00000003;
        tick();
        chk("b2b_ack0", 32'(ready), 32'd1);
        address = 16'h0008; wdata = 32'h00000000;
        tick();
        chk("b2b_ack1", 32'(ready), 32'd1);
        address = 16'h1000; wdata = 32'h80FF00FF;
        tick();
        chk("b2b_ack2", 32'(ready), 32'd1);
        address = 16'h3000; wdata = 32'h00000000;
        tick();
        chk("b2b_ack3", 32'(ready), 32'd1);
        request = 1'b0;
        tick();
        chk("b2b_ack_end", 32'(ready), 32'd0);
        // Control must be 3 and palette[0] = 0x80FF00FF
        pixel("b2b_effect", 24'h00FF00, 8'd0, 1'b1, 24'h807E80);
        pixel("b2b_pal5_kept", 24'h00FF00, 8'd5, 1'b1, 24'h00FF00);

        // Blanking pulse: outputs follow inputs two cycles later
        hb_pat  = 6'b000110;
        vb_pat  = 6'b010000;
        fb_in   = 24'h112233;
        mask_in = 1'b0;
        hb_in   = 1'b0;
        vb_in   = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            hb_in = hb_pat[i];
            vb_in = vb_pat[i];
            tick();
            if (i >= 1) begin
                chk("blank_hb", 32'(hb_out), 32'(hb_pat[i-1]));
                chk("blank_vb", 32'(vb_out), 32'(vb_pat[i-1]));
                chk("blank_data", 32'(video_out),
                    (hb_pat[i-1] || vb_pat[i-1]) ? 32'h0 : 32'h112233);
            end
        end
        hb_in = 1'b0;
        vb_in = 1'b0;

        // Same-cycle write/read of palette[7]
        bus_write(16'h101C, 32'hFF0000FF);
        fb_in   = 24'h000000;
        ov_in   = 8'd7;
        mask_in = 1'b1;
        request = 1'b1;
        address = 16'h101C;
        wdata   = 32'hFF00FF00;
        tick();
        request = 1'b0;
        tick();
        chk("hazard_old", 32'(video_out), 32'h0000FF);
        tick();
        chk("hazard_new", 32'(video_out), 32'h00FF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
